// File: rtl/s2p_pkg.sv
// Shared helpers and FSM encoding for the multi-channel serial-to-parallel master.
package s2p_pkg;

    typedef logic [1:0] s2p_state_t;

    localparam s2p_state_t ST_IDLE  = 2'd0;
    localparam s2p_state_t ST_LOAD  = 2'd1;
    localparam s2p_state_t ST_SHIFT = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic bit params_legal(input int nbit, input int nch,
                                        input int ld_ticks, input int filt);
        return (nbit >= 2) && (nch >= 1) && (ld_ticks >= 1) && (filt >= 1);
    endfunction

endpackage

// File: rtl/s2p_sync_edge.sv
// Two-flop synchroniser; with RISE set, q is a one-cycle pulse on the synchronised rising edge.
module s2p_sync_edge #(
    parameter bit RISE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
        end
    end

    generate
        if (RISE) begin : g_rise
            logic s3_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s3_reg <= 1'b0;
                end else begin
                    s3_reg <= s2_reg;
                end
            end
            assign q = s2_reg & ~s3_reg;
        end else begin : g_level
            assign q = s2_reg;
        end
    endgenerate

endmodule

// File: rtl/s2p_master_mc.sv
// Drives shared sclk/sld_n onto NCH shift-register chains, captures one frame per chain
// and publishes it once FILT consecutive identical frames have been seen.
module s2p_master_mc
    import s2p_pkg::*;
#(
    parameter int NBIT     = 64,
    parameter int NCH      = 2,
    parameter int LD_TICKS = 2,
    parameter int FILT     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                en,
    input  logic [NCH-1:0]      si,
    output logic                sclk,
    output logic                sld_n,
    output logic [NCH*NBIT-1:0] po,
    output logic                po_vld,
    output logic                frame_done
);

    localparam int STEP_W = (clog2(LD_TICKS + 2*NBIT) < 1) ? 1 : clog2(LD_TICKS + 2*NBIT);
    localparam int BIT_W  = clog2(NBIT);
    localparam int CNT_W  = clog2(FILT + 1);

    localparam logic [STEP_W-1:0] LD_LAST = STEP_W'(LD_TICKS - 1);
    localparam logic [STEP_W-1:0] SH_LAST = STEP_W'(2*NBIT - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(FILT);

    generate
        if (!params_legal(NBIT, NCH, LD_TICKS, FILT)) begin : g_param_check
            $fatal(1, "s2p_master_mc: illegal parameter set");
        end
    endgenerate

    logic                     tick_pp;
    logic [NCH-1:0]           si_s;
    s2p_state_t               state_reg;
    logic [STEP_W-1:0]        step_reg;
    logic [STEP_W-1:0]        step_inc;
    logic [BIT_W-1:0]         bit_idx;
    logic                     sclk_reg;
    logic                     sld_n_reg;
    logic                     frame_done_reg;
    logic                     po_vld_reg;
    logic [NCH-1:0][NBIT-1:0] frame_reg;
    logic [NCH-1:0][NBIT-1:0] cand_reg;
    logic [NCH-1:0][NBIT-1:0] po_reg;
    logic [CNT_W-1:0]         match_cnt_reg;
    logic [CNT_W-1:0]         match_next;
    logic                     frame_match;

    s2p_sync_edge #(.RISE(1'b1)) u_tick_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tick),
        .q     (tick_pp)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_si_sync
            s2p_sync_edge #(.RISE(1'b0)) u_si_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (si[gi]),
                .q     (si_s[gi])
            );
        end
    endgenerate

    always_comb begin
        step_inc    = step_reg + 1'b1;
        // Odd shift steps are the sclk rises; rise n lands on frame bit n.
        bit_idx     = BIT_W'(step_inc >> 1);
        frame_match = (frame_reg == cand_reg);
        match_next  = CNT_W'(1);
        if (frame_match) begin
            match_next = (match_cnt_reg == CNT_SAT) ? CNT_SAT : match_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            step_reg       <= '0;
            sclk_reg       <= 1'b0;
            sld_n_reg      <= 1'b1;
            frame_done_reg <= 1'b0;
            frame_reg      <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (tick_pp) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (en) begin
                            state_reg <= ST_LOAD;
                            step_reg  <= '0;
                            sld_n_reg <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        if (step_reg == LD_LAST) begin
                            state_reg <= ST_SHIFT;
                            step_reg  <= '0;
                            sld_n_reg <= 1'b1;
                        end else begin
                            step_reg <= step_inc;
                        end
                    end
                    ST_SHIFT: begin
                        if (step_reg == SH_LAST) begin
                            // Frame boundary: the only point where en is looked at.
                            sclk_reg <= 1'b0;
                            step_reg <= '0;
                            if (en) begin
                                state_reg <= ST_LOAD;
                                sld_n_reg <= 1'b0;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            step_reg <= step_inc;
                            sclk_reg <= step_inc[0];
                            if (step_inc[0]) begin
                                for (int c = 0; c < NCH; c++) begin
                                    frame_reg[c][bit_idx] <= si_s[c];
                                end
                                if (step_inc == SH_LAST) begin
                                    frame_done_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        step_reg  <= '0;
                        sclk_reg  <= 1'b0;
                        sld_n_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg      <= '0;
            match_cnt_reg <= '0;
            po_reg        <= '0;
            po_vld_reg    <= 1'b0;
        end else begin
            po_vld_reg <= 1'b0;
            if (frame_done_reg) begin
                match_cnt_reg <= match_next;
                if (!frame_match) begin
                    cand_reg <= frame_reg;
                end
                if (match_next == CNT_SAT) begin
                    po_reg     <= frame_reg;
                    po_vld_reg <= 1'b1;
                end
            end
        end
    end

    assign sclk       = sclk_reg;
    assign sld_n      = sld_n_reg;
    assign po         = po_reg;
    assign po_vld     = po_vld_reg;
    assign frame_done = frame_done_reg;

endmodule
